data_mux_pipe: RTL and testbench

Pipelined, parametrised successor to the valid-tagged OR data mux: merges `NUM_INPUTS` tagged operands, each with its valid flag in the MSB, into one result through a registered reduction tree of configurable fan-in. It adds stall support, an aligned output valid, multi-driver collision detection with a saturating counter, and an optional hold-last-value mode. It sits at PHI-node merge points in generated datapaths where the flat combinational OR limits clock frequency.

---
 rtl/data_mux_pkg.sv | 51 +++++
 rtl/data_mux_or_node.sv | 39 +++
 rtl/data_mux_pipe.sv | 117 +++++++++++
 tb/tb_data_mux_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/data_mux_pkg.sv
// Shared sizing helpers for the pipelined valid-tagged OR merge tree.
package data_mux_pkg;

  // Each tree node carries its data plus the any/multi flags.
  localparam int unsigned NODE_CTRL_W = 2;
  localparam int unsigned MAX_INPUTS  = 64;

  // Integer ceil(log_b(n)); n is bounded by MAX_INPUTS, so 32 steps is ample.
  function automatic int unsigned clog_base(input int unsigned n, input int unsigned b);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v < n) begin
        v = v * b;
        r = r + 1;
      end
    end
    return r;
  endfunction

  function automatic int unsigned num_stages(input int unsigned n, input int unsigned b);
    int unsigned c;
    c = clog_base(n, b);
    return (c == 0) ? 1 : c;
  endfunction

  // Node count after s reductions (level 0 is the raw input slots).
  function automatic int unsigned nodes_at(input int unsigned n, input int unsigned b,
                                           input int unsigned s);
    int unsigned c;
    c = n;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < s) c = (c + b - 1) / b;
    end
    return c;
  endfunction

  // First node index of level s inside the flat stage-register vector (levels 1..L).
  function automatic int unsigned level_base(input int unsigned n, input int unsigned b,
                                             input int unsigned s);
    int unsigned base;
    base = 0;
    for (int unsigned t = 1; t < 32; t++) begin
      if (t < s) base = base + nodes_at(n, b, t);
    end
    return base;
  endfunction

endpackage

// File: rtl/data_mux_or_node.sv
// Combinational reduction node: ORs FAN_IN children and derives any/multi flags.
module data_mux_or_node
  import data_mux_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 32,
  parameter int unsigned FAN_IN   = 4
) (
  input  logic [FAN_IN*(IN_WIDTH+NODE_CTRL_W)-1:0] i_children,
  output logic [IN_WIDTH+NODE_CTRL_W-1:0]          o_node_c
);

  localparam int unsigned NODE_W = IN_WIDTH + NODE_CTRL_W;

  typedef struct packed {
    logic [IN_WIDTH-1:0] data;
    logic                any;
    logic                multi;
  } node_t;

  node_t w_child;
  node_t w_out;
  logic  w_seen;

  // Child data is already zero when invalid, so data is a plain OR.
  always_comb begin
    w_out   = '0;
    w_seen  = 1'b0;
    w_child = '0;
    for (int unsigned c = 0; c < FAN_IN; c++) begin
      w_child     = node_t'(i_children[c*NODE_W +: NODE_W]);
      w_out.data  = w_out.data | w_child.data;
      w_out.multi = w_out.multi | w_child.multi | (w_seen & w_child.any);
      w_seen      = w_seen | w_child.any;
    end
    w_out.any = w_seen;
    o_node_c  = w_out;
  end

endmodule

// File: rtl/data_mux_pipe.sv
// Pipelined valid-tagged OR merge with stall, collision flag/counter and optional hold.
module data_mux_pipe
  import data_mux_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 16,
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH  = IN_WIDTH,
  parameter int unsigned FAN_IN     = 4,
  parameter int unsigned HOLD_LAST  = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic [NUM_INPUTS*(IN_WIDTH+1)-1:0] in_data,
  input  logic                               clr_count,
  output logic [OUT_WIDTH-1:0]               ret,
  output logic                               ret_valid,
  output logic                               collision,
  output logic [15:0]                        collision_count
);

  localparam int unsigned L           = num_stages(NUM_INPUTS, FAN_IN);
  localparam int unsigned SLOT_W      = IN_WIDTH + 1;
  localparam int unsigned NODE_W      = IN_WIDTH + NODE_CTRL_W;
  localparam int unsigned TOTAL_NODES = level_base(NUM_INPUTS, FAN_IN, L + 1);
  localparam int unsigned LAST_LSB    = level_base(NUM_INPUTS, FAN_IN, L) * NODE_W;

  typedef struct packed {
    logic [IN_WIDTH-1:0] data;
    logic                any;
    logic                multi;
  } node_t;

  logic [NUM_INPUTS*NODE_W-1:0]  w_lvl0;
  logic [TOTAL_NODES*NODE_W-1:0] w_tree;
  logic [TOTAL_NODES*NODE_W-1:0] r_tree;
  node_t                         w_last_q;
  logic                          w_next_multi;
  logic [15:0]                   r_count;

  // Level 0: zero the data of every invalid slot.
  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_mask
    logic w_vld;
    assign w_vld = in_data[k*SLOT_W + IN_WIDTH];
    assign w_lvl0[k*NODE_W +: NODE_W] =
      {in_data[k*SLOT_W +: IN_WIDTH] & {IN_WIDTH{w_vld}}, w_vld, 1'b0};
  end

  // Reduction levels; short final groups are padded with invalid zero children.
  for (genvar s = 1; s <= L; s++) begin : g_stage
    localparam int unsigned M_IN  = nodes_at(NUM_INPUTS, FAN_IN, s - 1);
    localparam int unsigned M_OUT = nodes_at(NUM_INPUTS, FAN_IN, s);
    localparam int unsigned B_IN  = level_base(NUM_INPUTS, FAN_IN, s - 1);
    localparam int unsigned B_OUT = level_base(NUM_INPUTS, FAN_IN, s);
    for (genvar j = 0; j < M_OUT; j++) begin : g_node
      logic [FAN_IN*NODE_W-1:0] w_kids;
      for (genvar c = 0; c < FAN_IN; c++) begin : g_kid
        if (j*FAN_IN + c >= M_IN) begin : g_pad
          assign w_kids[c*NODE_W +: NODE_W] = '0;
        end else if (s == 1) begin : g_in
          assign w_kids[c*NODE_W +: NODE_W] = w_lvl0[(j*FAN_IN + c)*NODE_W +: NODE_W];
        end else begin : g_reg
          assign w_kids[c*NODE_W +: NODE_W] = r_tree[(B_IN + j*FAN_IN + c)*NODE_W +: NODE_W];
        end
      end
      data_mux_or_node #(
        .IN_WIDTH (IN_WIDTH),
        .FAN_IN   (FAN_IN)
      ) u_node (
        .i_children (w_kids),
        .o_node_c   (w_tree[(B_OUT + j)*NODE_W +: NODE_W])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tree <= '0;
    end else if (en) begin
      r_tree <= w_tree;
    end
  end

  assign w_last_q     = node_t'(r_tree[LAST_LSB +: NODE_W]);
  assign w_next_multi = w_tree[LAST_LSB];
  assign ret_valid    = w_last_q.any;
  assign collision    = w_last_q.multi;

  // Hold register loads from the value entering the last stage so it stays aligned.
  if (HOLD_LAST != 0) begin : g_hold
    logic [OUT_WIDTH-1:0] r_hold;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_hold <= '0;
      end else if (en && w_tree[LAST_LSB + 1]) begin
        r_hold <= OUT_WIDTH'(w_tree[LAST_LSB + NODE_CTRL_W +: IN_WIDTH]);
      end
    end
    assign ret = r_hold;
  end else begin : g_pass
    assign ret = OUT_WIDTH'(w_last_q.data);
  end

  // Saturating collision counter; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr_count) begin
      r_count <= '0;
    end else if (en && w_next_multi && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign collision_count = r_count;

endmodule

// File: tb/tb_data_mux_pipe.sv
// Directed bench for data_mux_pipe: main, hold-last, odd-size/narrow and single-input builds.
module tb_data_mux_pipe;

  logic clk = 1'b0;
  logic reset, en, clr_count;

  logic [16*33-1:0] d16, dh;
  logic [5*33-1:0]  d5;
  logic [32:0]      d1;

  logic [31:0] ret16, reth, ret1;
  logic [7:0]  ret5;
  logic        v16, c16, vh, ch, v5, c5, v1, c1;
  logic [15:0] n16, nh, n5, n1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mux_pipe #(.NUM_INPUTS(16), .IN_WIDTH(32), .OUT_WIDTH(32), .FAN_IN(4), .HOLD_LAST(0)) u_dut (
    .clk(clk), .reset(reset), .en(en), .in_data(d16), .clr_count(clr_count),
    .ret(ret16), .ret_valid(v16), .collision(c16), .collision_count(n16));

  data_mux_pipe #(.NUM_INPUTS(16), .IN_WIDTH(32), .OUT_WIDTH(32), .FAN_IN(4), .HOLD_LAST(1)) u_hold (
    .clk(clk), .reset(reset), .en(en), .in_data(dh), .clr_count(clr_count),
    .ret(reth), .ret_valid(vh), .collision(ch), .collision_count(nh));

  data_mux_pipe #(.NUM_INPUTS(5), .IN_WIDTH(32), .OUT_WIDTH(8), .FAN_IN(4), .HOLD_LAST(0)) u_n5 (
    .clk(clk), .reset(reset), .en(en), .in_data(d5), .clr_count(clr_count),
    .ret(ret5), .ret_valid(v5), .collision(c5), .collision_count(n5));

  data_mux_pipe #(.NUM_INPUTS(1), .IN_WIDTH(32), .OUT_WIDTH(32), .FAN_IN(4), .HOLD_LAST(0)) u_n1 (
    .clk(clk), .reset(reset), .en(en), .in_data(d1), .clr_count(clr_count),
    .ret(ret1), .ret_valid(v1), .collision(c1), .collision_count(n1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put16(input int k, input logic v, input logic [31:0] d);
    d16[k*33 +: 33] = {v, d};
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; clr_count = 1'b0;
    d16 = '0; dh = '0; d5 = '0; d1 = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ret", 64'(ret16), 64'h0);
    chk("rst_valid", 64'(v16), 64'h0);
    chk("rst_coll", 64'(c16), 64'h0);
    chk("rst_count", 64'(n16), 64'h0);

    // Single valid slot on each build; N=1 emerges after one edge, the rest after two.
    put16(5, 1'b1, 32'hDEADBEEF);
    d5[4*33 +: 33] = {1'b1, 32'h0000ABCD};
    d1 = {1'b1, 32'h000055AA};
    tick();
    d16 = '0; d5 = '0; d1 = '0;
    chk("n1_ret", 64'(ret1), 64'h55AA);
    chk("n1_valid", 64'(v1), 64'h1);
    chk("n5_valid_early", 64'(v5), 64'h0);
    chk("single_valid_early", 64'(v16), 64'h0);
    tick();
    chk("single_ret", 64'(ret16), 64'hDEADBEEF);
    chk("single_valid", 64'(v16), 64'h1);
    chk("single_coll", 64'(c16), 64'h0);
    chk("n5_ret", 64'(ret5), 64'hCD);
    chk("n5_valid", 64'(v5), 64'h1);
    chk("n1_valid_after", 64'(v1), 64'h0);
    tick();
    chk("zero_ret", 64'(ret16), 64'h0);
    chk("zero_valid", 64'(v16), 64'h0);
    chk("zero_coll", 64'(c16), 64'h0);

    // Two drivers: data still ORs, collision flagged and counted.
    put16(0, 1'b1, 32'h0F);
    put16(3, 1'b1, 32'hF0);
    tick();
    d16 = '0;
    tick();
    chk("coll_ret", 64'(ret16), 64'hFF);
    chk("coll_valid", 64'(v16), 64'h1);
    chk("coll_flag", 64'(c16), 64'h1);
    chk("coll_count1", 64'(n16), 64'h1);

    // Every slot valid with data k: OR of 0..15 is 0xF.
    for (int k = 0; k < 16; k++) put16(k, 1'b1, 32'(k));
    tick();
    d16 = '0;
    tick();
    chk("all_ret", 64'(ret16), 64'hF);
    chk("all_coll", 64'(c16), 64'h1);
    chk("all_count2", 64'(n16), 64'h2);

    // Sustained collisions saturate the counter.
    put16(0, 1'b1, 32'h0F);
    put16(3, 1'b1, 32'hF0);
    for (int i = 0; i < 65540; i++) tick();
    chk("sat_count", 64'(n16), 64'hFFFF);
    chk("sat_coll", 64'(c16), 64'h1);

    // Clear while an increment is pending: clear wins.
    clr_count = 1'b1;
    d16 = '0;
    tick();
    chk("clr_wins", 64'(n16), 64'h0);
    tick(); tick();
    clr_count = 1'b0;
    chk("clr_hold", 64'(n16), 64'h0);

    // Stall: freeze with a valid result showing; in_data ignored while stalled.
    put16(2, 1'b1, 32'h11);
    tick();
    d16 = '0;
    put16(9, 1'b1, 32'h22);
    tick();
    en = 1'b0;
    d16 = '0;
    put16(1, 1'b1, 32'hFFFF);
    put16(4, 1'b1, 32'h1000);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_ret", 64'(ret16), 64'h11);
    chk("stall_valid", 64'(v16), 64'h1);
    chk("stall_coll", 64'(c16), 64'h0);
    chk("stall_count", 64'(n16), 64'h0);
    en = 1'b1;
    d16 = '0;
    tick();
    chk("resume_ret", 64'(ret16), 64'h22);
    chk("resume_valid", 64'(v16), 64'h1);
    tick();
    chk("resume_flush_valid", 64'(v16), 64'h0);
    chk("resume_flush_count", 64'(n16), 64'h0);

    // Hold-last vs. zeroing output on the same stimulus.
    put16(0, 1'b1, 32'h1234);
    dh = d16;
    tick();
    d16 = '0; dh = '0;
    tick();
    chk("hold_ret_live", 64'(reth), 64'h1234);
    chk("hold_valid_live", 64'(vh), 64'h1);
    tick(); tick(); tick();
    chk("hold_ret_held", 64'(reth), 64'h1234);
    chk("hold_valid_held", 64'(vh), 64'h0);
    chk("nohold_ret", 64'(ret16), 64'h0);
    chk("nohold_valid", 64'(v16), 64'h0);

    // Reset mid-stream drops in-flight data and clears outputs next edge.
    put16(7, 1'b1, 32'h77);
    put16(8, 1'b1, 32'h88);
    tick();
    d16 = '0;
    put16(8, 1'b1, 32'h88);
    tick();
    chk("pre_rst_coll", 64'(c16), 64'h1);
    chk("pre_rst_count", 64'(n16), 64'h1);
    reset = 1'b1;
    d16 = '0;
    tick();
    chk("midrst_ret", 64'(ret16), 64'h0);
    chk("midrst_valid", 64'(v16), 64'h0);
    chk("midrst_coll", 64'(c16), 64'h0);
    chk("midrst_count", 64'(n16), 64'h0);
    chk("midrst_hold", 64'(reth), 64'h0);
    reset = 1'b0;
    tick(); tick();
    chk("post_rst_valid", 64'(v16), 64'h0);
    chk("post_rst_ret", 64'(ret16), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
